// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states and latency class.
// Optional accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MADDU = 3'd5,
      OP_MSUB  = 3'd6,
      OP_MSUBU = 3'd7
   } mdu_op_e;

   typedef enum logic {
      LAT_MULT,
      LAT_DIV
   } mdu_lat_e;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } mdu_state_e;

   function automatic mdu_lat_e op_lat_class(mdu_op_e op);
      return (op == OP_DIV || op == OP_DIVU) ? LAT_DIV : LAT_MULT;
   endfunction

   // Ops 4-7 exist only when the accumulate datapath is compiled in.
   function automatic logic op_legal(mdu_op_e op);
`ifdef MDU_MADD_EN
      return (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
`else
      return (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
`endif
   endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational datapath: computes the next {HI,LO} for a latched op and whether to commit it.
// The accumulate adder (madd family) is built only when MDU_MADD_EN is defined.
module mdu_core
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2*WIDTH-1:0] hilo,
   output logic [2*WIDTH-1:0] hilo_next,
   output logic               commit
);

   mdu_op_e            op_e;
   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic               div_signed;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   b_safe;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   assign op_e = mdu_op_e'(op);

   // Sign-extended operands give the exact signed product in the low 2*WIDTH bits.
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

   // Signed divide via magnitudes: the most-negative / -1 case wraps naturally, and a
   // zero divisor is replaced by 1 so the divider never sees it (that result is discarded).
   assign div_signed = (op_e == OP_DIV);
   assign a_neg      = div_signed & a[WIDTH-1];
   assign b_neg      = div_signed & b[WIDTH-1];
   assign a_mag      = a_neg ? -a : a;
   assign b_mag      = b_neg ? -b : b;
   assign b_safe     = (b_mag == '0) ? WIDTH'(1) : b_mag;
   assign q_mag      = a_mag / b_safe;
   assign r_mag      = a_mag % b_safe;
   assign quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem        = a_neg ? -r_mag : r_mag;

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      hilo_next = hilo;
      commit    = 1'b0;
      case (op_e)
         OP_MULT: begin
            hilo_next = prod_s;
            commit    = 1'b1;
         end
         OP_MULTU: begin
            hilo_next = prod_u;
            commit    = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            hilo_next = {rem, quot};
            commit    = (b != '0);
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            hilo_next = hilo + prod_s;
            commit    = 1'b1;
         end
         OP_MADDU: begin
            hilo_next = hilo + prod_u;
            commit    = 1'b1;
         end
         OP_MSUB: begin
            hilo_next = hilo - prod_s;
            commit    = 1'b1;
         end
         OP_MSUBU: begin
            hilo_next = hilo - prod_u;
            commit    = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit top: IDLE/RUN FSM, latency counter, operand latches and HI/LO registers.
// Defining MDU_MADD_EN adds the madd/maddu/msub/msubu ops (MULT_CYCLES latency).
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   mdu_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [2*WIDTH-1:0] core_hilo;
   logic               core_commit;
   mdu_op_e            op_in;

   assign op_in = mdu_op_e'(op);

   mdu_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .op        (op_q),
      .a         (a_q),
      .b         (b_q),
      .hilo      ({hi_q, lo_q}),
      .hilo_next (core_hilo),
      .commit    (core_commit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            // start always wins over a move, even when the op itself turns out illegal.
            if (start) begin
               if (op_legal(op_in)) begin
                  op_d    = op;
                  a_d     = rs_val;
                  b_d     = rt_val;
                  cnt_d   = (op_lat_class(op_in) == LAT_DIV) ? DIV_LOAD : MULT_LOAD;
                  state_d = ST_RUN;
               end
            end else begin
               if (mthi) hi_d = rs_val;
               if (mtlo) lo_d = rs_val;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               if (core_commit) {hi_d, lo_d} = core_hilo;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases with literal expectations plus a randomized
// phase, all checked every cycle against a 64-bit arithmetic reference model.
module tb_mdu_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   mdu_unit #(
      .WIDTH       (32),
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .mthi   (mthi),
      .mtlo   (mtlo),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_legal(input logic [2:0] o);
`ifdef MDU_MADD_EN
      return 1'b1;
`else
      return (o < 3'd4);
`endif
   endfunction

   function automatic int model_latency(input logic [2:0] o);
      return (o == 3'd2 || o == 3'd3) ? 10 : 5;
   endfunction

   // Returns {commit, hi, lo} using plain 64-bit integer arithmetic.
   function automatic logic [64:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                                input logic [31:0] b, input logic [63:0] acc);
      longint          sa, sb, q, rm;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     ps, pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      ps = sa * sb;
      pu = ua * ub;
      case (o)
         3'd0: return {1'b1, ps};
         3'd1: return {1'b1, pu};
         3'd2: begin
            if (b == 32'd0) return {1'b0, acc};
            q  = sa / sb;
            rm = sa % sb;
            return {1'b1, rm[31:0], q[31:0]};
         end
         3'd3: begin
            if (b == 32'd0) return {1'b0, acc};
            uq = ua / ub;
            ur = ua % ub;
            return {1'b1, ur[31:0], uq[31:0]};
         end
         3'd4: return {1'b1, acc + ps};
         3'd5: return {1'b1, acc + pu};
         3'd6: return {1'b1, acc - ps};
         default: return {1'b1, acc - pu};
      endcase
   endfunction

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   int          m_left = 0;
   logic [64:0] m_pend = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi   <= '0;
         m_lo   <= '0;
         m_left <= 0;
         m_pend <= '0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1 && m_pend[64]) begin
            m_hi <= m_pend[63:32];
            m_lo <= m_pend[31:0];
         end
      end else if (start) begin
         if (model_legal(op)) begin
            m_pend <= model_result(op, rs_val, rt_val, {m_hi, m_lo});
            m_left <= model_latency(op);
         end
      end else begin
         if (mthi) m_hi <= rs_val;
         if (mtlo) m_lo <= rs_val;
      end
   end

   always @(negedge clk) begin
      check("busy", {31'b0, busy}, {31'b0, m_left != 0});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
   end

   // ---------------- directed helpers ----------------
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk); #1;
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int exp_len, input string name);
      int n;
      @(negedge clk); #1;
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(negedge clk); #1;
      start = 1'b0;
      wait_idle(n);
      check({name, "_busy_len"}, 32'(n), 32'(exp_len));
   endtask

   task automatic move(input logic wh, input logic wl, input logic [31:0] val);
      @(negedge clk); #1;
      mthi = wh; mtlo = wl; rs_val = val;
      @(negedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;

      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b1;

      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5, "mult");
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);

      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, "div");
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);

      run_op(3'd3, 32'd9, 32'd0, 10, "divu0");
      check("divu0_hi", hi, 32'hFFFF_FFFF);
      check("divu0_lo", lo, 32'hFFFF_FFFD);

      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, "wrap");
      check("wrap_lo", lo, 32'h8000_0000);
      check("wrap_hi", hi, 32'd0);

      // mthi during a no-commit divide must leave HI untouched
      @(negedge clk); #1;
      start = 1'b1; op = 3'd3; rs_val = 32'd9; rt_val = 32'd0;
      @(negedge clk); #1;
      start = 1'b0; mthi = 1'b1; rs_val = 32'h1234;
      @(negedge clk); #1;
      mthi = 1'b0;
      wait_idle(n);
      check("busy_mthi_hi", hi, 32'd0);

      move(1'b1, 1'b0, 32'h1234);
      check("idle_mthi_hi", hi, 32'h1234);

      // start with mtlo in the same cycle: the op result wins
      @(negedge clk); #1;
      start = 1'b1; mtlo = 1'b1; op = 3'd0; rs_val = 32'd2; rt_val = 32'd5;
      @(negedge clk); #1;
      start = 1'b0; mtlo = 1'b0;
      check("start_mtlo_lo_hold", lo, 32'h8000_0000);
      wait_idle(n);
      check("start_mtlo_lo", lo, 32'd10);
      check("start_mtlo_hi", hi, 32'd0);

      move(1'b1, 1'b1, 32'hFFFF_FFFF);
      check("both_hi", hi, 32'hFFFF_FFFF);
      check("both_lo", lo, 32'hFFFF_FFFF);
      move(1'b1, 1'b0, 32'd0);
`ifdef MDU_MADD_EN
      run_op(3'd5, 32'd1, 32'd1, 5, "maddu");
      check("maddu_hi", hi, 32'd1);
      check("maddu_lo", lo, 32'd0);
`else
      run_op(3'd5, 32'd1, 32'd1, 0, "maddu");
      check("maddu_hi", hi, 32'd0);
      check("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

      // reset pulled in the 3rd busy cycle of a multiply
      @(negedge clk); #1;
      start = 1'b1; op = 3'd0; rs_val = 32'd7; rt_val = 32'd7;
      @(negedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      check("pre_rst_busy", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      @(negedge clk); #1;
      reset = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      check("postrst_busy", {31'b0, busy}, 32'd0);
      check("postrst_hi", hi, 32'd0);
      check("postrst_lo", lo, 32'd0);

      // randomized traffic, including inputs the unit must ignore while busy
      repeat (4000) begin
         @(negedge clk); #1;
         start  = ($urandom_range(0, 3) == 0);
         op     = 3'($urandom_range(0, 7));
         rs_val = pick_operand();
         rt_val = pick_operand();
         mthi   = ($urandom_range(0, 5) == 0);
         mtlo   = ($urandom_range(0, 5) == 0);
      end
      @(negedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      repeat (15) @(negedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multiply/divide unit for the execute stage of the pipelined MIPS core. It performs the HI/LO-writing instructions (mult, multu, div, divu, optional madd family) with a fixed, parametrised latency and exposes a busy flag. The hazard unit uses that flag to stall mfhi/mflo/mthi/mtlo and further multiply/divide issue. HI/LO move instructions are also serviced here, so HI and LO live only in this block.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for mult/multu/madd family (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- start  in  1  issue strobe for an arithmetic op from the E stage
- op  in  3  operation code, from the package encoding
- rs_val  in  WIDTH  operand A; also the write data for mthi/mtlo
- rt_val  in  WIDTH  operand B
- mthi  in  1  write rs_val to HI
- mtlo  in  1  write rs_val to LO
- busy  out  1  operation in flight (registered)
- hi  out  WIDTH  current HI register
- lo  out  WIDTH  current LO register

## Operation
- Op encoding: MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MADDU=5, MSUB=6, MSUBU=7.
- States: IDLE and RUN.
- IDLE behaviour:
  - start=1 with a legal op accepts the op. The unit latches op, rs_val and rt_val, loads the counter with MULT_CYCLES or DIV_CYCLES, and moves to RUN.
- RUN behaviour:
  - The counter decrements each cycle.
  - When the counter reaches 1, the pending result is committed to HI/LO at that edge and the state returns to IDLE.
- Results:
  - mult/multu: {HI,LO} = full 2·WIDTH signed/unsigned product.
  - div/divu: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Signed div of most-negative value by −1: LO = most-negative value, HI = 0 (wrap, no trap).
  - Divide by zero: takes the full DIV_CYCLES; HI/LO are left unchanged.
  - madd/maddu: {HI,LO} += product. msub/msubu: {HI,LO} −= product. Arithmetic is modulo 2^(2·WIDTH) and uses the HI/LO value at commit time.
- Moves:
  - mthi/mtlo are honoured only in IDLE; they write at the next edge.
- Ignored inputs while busy=1:
  - start, mthi and mtlo are all ignored; the hazard unit guarantees they are stalled.
- Same-cycle conflicts in IDLE:
  - start together with mthi/mtlo: start takes priority and the move is dropped.
  - mthi and mtlo together: both are written.
- Illegal op: with start=1 and an op that is not compiled in, nothing happens; busy stays 0 and HI/LO are unchanged.

## Timing
- Reset values: busy=0, hi=0, lo=0, state IDLE, counter 0, pending result discarded. Reset asserted mid-RUN aborts the op with no commit.
- Accept and busy window:
  - start is accepted at edge k.
  - busy is 1 from just after edge k until just after edge k+N, where N is the latency for that op.
  - The result on hi/lo and busy=0 become visible together after edge k+N.
- A new start can be accepted at edge k+N+1, the first edge after busy falls.
- busy is registered, so it does not cover the start cycle itself. The stall condition in the hazard unit is (start | busy) for dependent instructions.
- mthi/mtlo latency: 1 edge; the new value is visible on hi/lo the following cycle.
- No combinational path from any input to any output.

## Configuration
- MDU_MADD_EN defined: ops 4–7 (madd, maddu, msub, msubu) are implemented and use MULT_CYCLES.
- MDU_MADD_EN undefined: ops 4–7 are illegal and handled per the illegal-op rule; the accumulate adder is not built.

## Structure
- Shared package mdu_pkg holds:
  - the op encoding constants and op enum typedef;
  - the function mapping an op to its latency class.
- Sub-module mdu_core is combinational. It takes the latched op, operands and current {HI,LO} and produces the next {HI,LO} and a commit-enable. The commit-enable is 0 for divide by zero and for illegal ops.
- The top level holds the FSM, the counter, the operand latches and the HI/LO registers.

## Test plan
- Signed multiply: reset released, mult with rs=0xFFFFFFFE, rt=3 → busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Divide and divide by zero:
  - div rs=−7, rt=2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu rs=9, rt=0 → 10 busy cycles, HI/LO unchanged.
- Wrap case: div rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- Moves while busy:
  - mthi 0x1234 while busy → ignored.
  - mthi 0x1234 in IDLE → HI=0x1234 one cycle later.
  - start with mtlo in the same IDLE cycle → LO is set by the op, not by the move.
- MDU_MADD_EN on: HI=0, LO=0xFFFFFFFF, then maddu rs=1, rt=1 → HI=1, LO=0. MDU_MADD_EN off: same stimulus → busy stays 0, HI/LO unchanged.
- Reset mid-op: pull reset low in the 3rd busy cycle of mult → busy, hi and lo go to 0 immediately; no late commit after release.
